// File: rtl/bram_stream_reader.sv
// Streams pi_len words from BRAM starting at pi_base; first beat 3 cycles after pi_start.
// Reads are throttled so buffered plus in-flight words never exceed the 2-entry buffer under backpressure.
module bram_stream_reader #(
    parameter int WADDR = 11,
    parameter int WDATA = 16
) (
    input  logic             pi_clk,
    input  logic             pi_rst,
    input  logic             pi_start,
    input  logic [WADDR-1:0] pi_base,
    input  logic [WADDR:0]   pi_len,
    output logic             po_busy,
    output logic             po_done,
    output logic             po_bram_en,
    output logic             po_bram_we,
    output logic [WADDR-1:0] po_bram_addr,
    input  logic [WDATA-1:0] pi_bram_do,
    output logic [WDATA-1:0] po_tdata,
    output logic             po_tvalid,
    input  logic             pi_tready,
    output logic             po_tlast
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [WADDR-1:0] ADDR_ONE = 1;
    localparam logic [WADDR:0]   CNT_ONE  = 1;

    state_t           state, state_nxt;
    logic [WADDR:0]   reads_left;
    logic [WADDR:0]   beats_left;
    logic             in_flight;
    logic [1:0]       buf_cnt;
    logic [WDATA-1:0] buf_mem [2];
    logic             rd_ptr, wr_ptr;
    logic             push, pop, issue;
    logic [2:0]       occ;

    // Occupancy the buffer will need to absorb, net of the beat leaving this cycle
    assign occ        = {1'b0, buf_cnt} + {2'b0, in_flight} - {2'b0, pop};
    assign push       = in_flight;
    assign pop        = po_tvalid & pi_tready;
    assign issue      = (state == S_RUN) && (reads_left != '0) && (occ < 3'd2);

    assign po_bram_en = issue;
    assign po_bram_we = 1'b0;
    assign po_tvalid  = (buf_cnt != 2'd0);
    assign po_tdata   = buf_mem[rd_ptr];
    assign po_tlast   = po_tvalid && (beats_left == CNT_ONE);

    always_comb begin
        state_nxt = state;
        po_busy   = (state != S_IDLE);
        po_done   = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (pi_start) state_nxt = (pi_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (issue && (reads_left == CNT_ONE)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && po_tlast) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state        <= S_IDLE;
            po_bram_addr <= '0;
            reads_left   <= '0;
            beats_left   <= '0;
            in_flight    <= 1'b0;
            buf_cnt      <= 2'd0;
            buf_mem[0]   <= '0;
            buf_mem[1]   <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_flight <= issue;
            if (state == S_IDLE && pi_start) begin
                po_bram_addr <= pi_base;
                reads_left   <= pi_len;
                beats_left   <= pi_len;
            end
            if (issue) begin
                po_bram_addr <= po_bram_addr + ADDR_ONE;
                reads_left   <= reads_left - CNT_ONE;
            end
            if (pop) begin
                beats_left <= beats_left - CNT_ONE;
                rd_ptr     <= ~rd_ptr;
            end
            if (push) begin
                buf_mem[wr_ptr] <= pi_bram_do;
                wr_ptr          <= ~wr_ptr;
            end
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
